// File: rtl/lsu_pkg.sv
// Load/store unit shared types and helpers.
// State encoding, RV32I width codes and request legality checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    RMW
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic half_bad;
    logic word_bad;
    half_bad = ((f3 == F3_H) || (f3 == F3_HU)) && lo[0];
    word_bad = (f3 == F3_W) && (lo != 2'b00);
    return half_bad || word_bad;
  endfunction

  function automatic logic is_legal(
    input logic       st,
    input logic [2:0] f3
  );
    logic base;
    base = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (st) return base;
    return base || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage to load/store unit request and result bundle.
// master = execute side, slave = load/store unit.
interface lsu_if #(
  parameter int TID_W = 2
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TID_W-1:0] req_tid;
  logic [4:0]       req_rd;
  logic             ld_valid;
  logic [31:0]      ld_data;
  logic [TID_W-1:0] ld_tid;
  logic [4:0]       ld_rd;
  logic             err_valid;
  logic [TID_W-1:0] err_tid;

  modport master (
    output req_valid, req_is_store, req_funct3,
    output req_addr, req_wdata, req_tid, req_rd,
    input  req_ready,
    input  ld_valid, ld_data, ld_tid, ld_rd,
    input  err_valid, err_tid
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3,
    input  req_addr, req_wdata, req_tid, req_rd,
    output req_ready,
    output ld_valid, ld_data, ld_tid, ld_rd,
    output err_valid, err_tid
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling for the load/store unit.
// merge=0: extract and extend a load; merge=1: splice store data into word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        merge,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane, then extend it or replace it
  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    result = word;
    if (merge) begin
      unique case (funct3)
        F3_B: result[{lane, 3'b000} +: 8] = wdata[7:0];
        F3_H: begin
          if (lane[1]) result[31:16] = wdata[15:0];
          else         result[15:0]  = wdata[15:0];
        end
        default: result = wdata;
      endcase
    end else begin
      unique case (funct3)
        F3_B:    result = {{24{byte_v[7]}}, byte_v};
        F3_H:    result = {{16{half_v[15]}}, half_v};
        F3_BU:   result = {24'h0, byte_v};
        F3_HU:   result = {16'h0, half_v};
        default: result = word;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: loads, stores and sub-word read-modify-write
// against a 128-word data memory with one-cycle read latency.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int INDEX_W = 7,
  parameter int TID_W   = 2
) (
  input  logic               clk,
  input  logic               nReset,
  lsu_if.slave               bus,
  output logic               WriteCache,
  output logic               ReadEnable,
  output logic [INDEX_W-1:0] CacheIndexWrite,
  output logic [INDEX_W-1:0] CacheIndexRead,
  output logic [31:0]        WriteDataCache,
  input  logic [31:0]        CacheData
);

  state_t             state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic [4:0]         rd_q, rd_d;
  logic               ld_valid_q, ld_valid_d;
  logic [31:0]        ld_data_q, ld_data_d;
  logic [TID_W-1:0]   ld_tid_q, ld_tid_d;
  logic [4:0]         ld_rd_q, ld_rd_d;
  logic               err_valid_q, err_valid_d;
  logic [TID_W-1:0]   err_tid_q, err_tid_d;

  logic               accept;
  logic               bad;
  logic               do_err;
  logic               do_ld;
  logic               do_sw;
  logic               do_rmw;
  logic               rd_en;
  logic               wr_en;
  logic               ready;
  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] idx_w;
  logic [31:0]        wd;
  logic [31:0]        load_data;
  logic [31:0]        merge_data;
  logic               unused_addr;

  assign req_idx     = bus.req_addr[INDEX_W+1:2];
  assign unused_addr = ^bus.req_addr[31:INDEX_W+2];

  assign accept = nReset && (state_q == IDLE) && bus.req_valid;
  assign bad    = !is_legal(bus.req_is_store, bus.req_funct3) ||
                  is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign do_err = accept && bad;
  assign do_ld  = accept && !bad && !bus.req_is_store;
  assign do_sw  = accept && !bad && bus.req_is_store &&
                  (bus.req_funct3 == F3_W);
  assign do_rmw = accept && !bad && bus.req_is_store &&
                  (bus.req_funct3 != F3_W);

  lsu_lane_align u_ld_align (
    .merge  (1'b0),
    .funct3 (f3_q),
    .lane   (lane_q),
    .word   (CacheData),
    .wdata  (32'h0),
    .result (load_data)
  );

  lsu_lane_align u_st_merge (
    .merge  (1'b1),
    .funct3 (f3_q),
    .lane   (lane_q),
    .word   (CacheData),
    .wdata  (wdata_q),
    .result (merge_data)
  );

  // Next state, memory strobes and registered result updates
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    tid_d       = tid_q;
    rd_d        = rd_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    ld_tid_d    = ld_tid_q;
    ld_rd_d     = ld_rd_q;
    err_valid_d = 1'b0;
    err_tid_d   = err_tid_q;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    ready       = 1'b0;
    idx_w       = idx_q;
    wd          = merge_data;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (do_ld || do_rmw) begin
          f3_d    = bus.req_funct3;
          lane_d  = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          idx_d   = req_idx;
          tid_d   = bus.req_tid;
          rd_d    = bus.req_rd;
        end
        unique case (1'b1)
          do_err: begin
            err_valid_d = 1'b1;
            err_tid_d   = bus.req_tid;
          end
          do_ld: begin
            rd_en   = 1'b1;
            state_d = LD_WAIT;
          end
          do_sw: begin
            wr_en = 1'b1;
            idx_w = req_idx;
            wd    = bus.req_wdata;
          end
          do_rmw: begin
            rd_en   = 1'b1;
            state_d = RMW;
          end
          default: ;
        endcase
      end
      LD_WAIT: begin
        ld_valid_d = 1'b1;
        ld_data_d  = load_data;
        ld_tid_d   = tid_q;
        ld_rd_d    = rd_q;
        state_d    = IDLE;
      end
      RMW: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered results
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      tid_q       <= '0;
      rd_q        <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      ld_tid_q    <= '0;
      ld_rd_q     <= '0;
      err_valid_q <= 1'b0;
      err_tid_q   <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      tid_q       <= tid_d;
      rd_q        <= rd_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      ld_tid_q    <= ld_tid_d;
      ld_rd_q     <= ld_rd_d;
      err_valid_q <= err_valid_d;
      err_tid_q   <= err_tid_d;
    end
  end

  assign bus.req_ready   = nReset && ready;
  assign ReadEnable      = nReset && rd_en;
  assign WriteCache      = nReset && wr_en;
  assign CacheIndexRead  = req_idx;
  assign CacheIndexWrite = idx_w;
  assign WriteDataCache  = wd;
  assign bus.ld_valid    = ld_valid_q;
  assign bus.ld_data     = ld_data_q;
  assign bus.ld_tid      = ld_tid_q;
  assign bus.ld_rd       = ld_rd_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_tid     = err_tid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural memory plus a
// word-array reference model, directed cases then random traffic.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        WriteCache;
  logic        ReadEnable;
  logic [6:0]  CacheIndexWrite;
  logic [6:0]  CacheIndexRead;
  logic [31:0] WriteDataCache;
  logic [31:0] CacheData;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  bit          mem_init = 1'b0;
  logic [2:0]  ld_f3s  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  lsu_if #(.TID_W(2)) bus ();

  load_store_unit #(.INDEX_W(7), .TID_W(2)) dut (
    .clk             (clk),
    .nReset          (nReset),
    .bus             (bus.slave),
    .WriteCache      (WriteCache),
    .ReadEnable      (ReadEnable),
    .CacheIndexWrite (CacheIndexWrite),
    .CacheIndexRead  (CacheIndexRead),
    .WriteDataCache  (WriteDataCache),
    .CacheData       (CacheData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Data memory: one-cycle read latency, write at the clock edge
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_word(i);
      mem_init <= 1'b1;
    end else begin
      if (WriteCache) mem[CacheIndexWrite] <= WriteDataCache;
      if (ReadEnable) CacheData <= mem[CacheIndexRead];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_bad(input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit legal;
    if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                 (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    logic [31:0] w;
    int          off;
    int          v;
    w   = ref_mem[(a / 4) % 128];
    off = int'(a % 4);
    case (f3)
      3'd0: begin
        v = int'((w >> (off * 8)) & 32'hFF);
        if (v > 127) v = v - 256;
        return v;
      end
      3'd4: return (w >> (off * 8)) & 32'hFF;
      3'd1: begin
        v = int'((w >> ((off / 2) * 16)) & 32'hFFFF);
        if (v > 32767) v = v - 65536;
        return v;
      end
      3'd5: return (w >> ((off / 2) * 16)) & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] wd);
    logic [31:0] w;
    int          sh;
    w = ref_mem[(a / 4) % 128];
    if (f3 == 3'd0) begin
      sh = int'(a % 4) * 8;
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    if (f3 == 3'd1) begin
      sh = (int'(a % 4) / 2) * 16;
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic op(input bit st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] tid, input logic [4:0] rd);
    bit          bad;
    bit          sw;
    bit          multi;
    logic [6:0]  idx;
    logic [31:0] exp;
    bad   = ref_bad(st, f3, a);
    idx   = 7'((a / 4) % 128);
    sw    = !bad && st && (f3 == 3'd2);
    multi = !bad && !sw;
    check_eq("ready_idle", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_tid      = tid;
    bus.req_rd       = rd;
    #1;
    check_eq("rd_en_t0", ReadEnable, multi);
    check_eq("wr_en_t0", WriteCache, sw);
    if (multi) check_eq("rd_idx", CacheIndexRead, idx);
    if (sw) begin
      check_eq("sw_idx", CacheIndexWrite, idx);
      check_eq("sw_data", WriteDataCache, wd);
    end
    @(negedge clk);
    if (multi) begin
      bus.req_valid    = 1'($urandom_range(0, 1));
      bus.req_is_store = 1'($urandom);
      bus.req_funct3   = 3'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      bus.req_tid      = 2'($urandom);
      bus.req_rd       = 5'($urandom);
    end else begin
      bus.req_valid = 1'b0;
    end
    #1;
    check_eq("err_valid", bus.err_valid, bad);
    if (bad) check_eq("err_tid", bus.err_tid, tid);
    check_eq("ld_valid_t1", bus.ld_valid, 0);
    check_eq("ready_t1", bus.req_ready, !multi);
    if (multi) begin
      check_eq("rd_en_t1", ReadEnable, 0);
      check_eq("wr_en_t1", WriteCache, st);
      if (st) begin
        check_eq("rmw_idx", CacheIndexWrite, idx);
        check_eq("rmw_data", WriteDataCache, ref_merge(f3, a, wd));
      end
      exp = ref_load(f3, a);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      check_eq("ld_valid_t2", bus.ld_valid, !st);
      check_eq("err_valid_t2", bus.err_valid, 0);
      check_eq("ready_t2", bus.req_ready, 1);
      if (!st) begin
        check_eq("ld_data", bus.ld_data, exp);
        check_eq("ld_tid", bus.ld_tid, tid);
        check_eq("ld_rd", bus.ld_rd, rd);
      end
    end
    if (!bad && st) ref_mem[idx] = ref_merge(f3, a, wd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ld_valid"}, bus.ld_valid, 0);
    check_eq({tag, "_ld_data"}, bus.ld_data, 0);
    check_eq({tag, "_ld_tid"}, bus.ld_tid, 0);
    check_eq({tag, "_ld_rd"}, bus.ld_rd, 0);
    check_eq({tag, "_err_valid"}, bus.err_valid, 0);
    check_eq({tag, "_err_tid"}, bus.err_tid, 0);
  endtask

  task automatic reset_mid(input bit st);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = st ? 3'd1 : 3'd0;
    bus.req_addr     = 32'h0000_0032;
    bus.req_wdata    = 32'h0000_BEEF;
    bus.req_tid      = 2'd3;
    bus.req_rd       = 5'd9;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    nReset        = 1'b0;
    #1;
    check_eq("mid_rst_wr", WriteCache, 0);
    check_eq("mid_rst_rd", ReadEnable, 0);
    check_eq("mid_rst_ready", bus.req_ready, 0);
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #2;
    nReset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_rst_ready", bus.req_ready, 1);
    check_reset_outputs("post_rst");
    check_eq("post_rst_mem", mem[12], ref_mem[12]);
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 128; i++) ref_mem[i] = seed_word(i);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'd2;
    bus.req_addr     = 32'h0000_0040;
    bus.req_wdata    = 32'hFFFF_FFFF;
    bus.req_tid      = 2'd0;
    bus.req_rd       = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_wr", WriteCache, 0);
    check_eq("rst_rd", ReadEnable, 0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    nReset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("rst");

    op(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 2'd1, 5'd0);
    op(1'b0, 3'd2, 32'h010, 32'h0, 2'd2, 5'd7);
    check_eq("lw_const", bus.ld_data, 32'hDEADBEEF);

    op(1'b1, 3'd2, 32'h020, 32'h11223344, 2'd0, 5'd0);
    op(1'b1, 3'd0, 32'h022, 32'h000000AA, 2'd3, 5'd0);
    check_eq("sb_mem", mem[8], 32'h11AA3344);

    op(1'b1, 3'd2, 32'h030, 32'h80F07F01, 2'd0, 5'd0);
    op(1'b0, 3'd0, 32'h033, 32'h0, 2'd1, 5'd1);
    check_eq("lb_const", bus.ld_data, 32'hFFFFFF80);
    op(1'b0, 3'd4, 32'h033, 32'h0, 2'd2, 5'd2);
    check_eq("lbu_const", bus.ld_data, 32'h00000080);
    op(1'b0, 3'd1, 32'h032, 32'h0, 2'd3, 5'd3);
    check_eq("lh_const", bus.ld_data, 32'hFFFF80F0);
    op(1'b0, 3'd5, 32'h030, 32'h0, 2'd0, 5'd4);
    check_eq("lhu_const", bus.ld_data, 32'h00007F01);

    op(1'b0, 3'd2, 32'h012, 32'h0, 2'd2, 5'd5);
    op(1'b1, 3'd1, 32'h031, 32'h1234, 2'd1, 5'd0);
    op(1'b0, 3'd3, 32'h030, 32'h0, 2'd3, 5'd6);
    op(1'b1, 3'd3, 32'h030, 32'h5555, 2'd2, 5'd0);
    op(1'b1, 3'd4, 32'h030, 32'h5555, 2'd1, 5'd0);
    check_eq("err_mem4", mem[4], 32'hDEADBEEF);
    check_eq("err_mem12", mem[12], 32'h80F07F01);

    op(1'b1, 3'd2, 32'h004, 32'h5, 2'd0, 5'd0);
    op(1'b0, 3'd2, 32'h204, 32'h0, 2'd1, 5'd8);
    check_eq("wrap_const", bus.ld_data, 32'h5);

    reset_mid(1'b1);
    check_eq("rmw_rst_const", mem[12], 32'h80F07F01);
    op(1'b0, 3'd2, 32'h030, 32'h0, 2'd3, 5'd10);
    reset_mid(1'b0);

    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3s[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (f3 == 3'd2) a = a & ~32'h3;
        if (f3 == 3'd1 || f3 == 3'd5) a = a & ~32'h1;
      end
      op(st, f3, a, $urandom, 2'($urandom), 5'($urandom));
    end

    for (int i = 0; i < 128; i++) check_eq("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the multithreaded RISC-V core, directly upstream of the 128-word data memory. Accepts one load or store per handshake from the execute stage, converts byte addresses into word indices, drives the memory's read/write ports, performs read-modify-write for byte and halfword stores, and returns aligned, sign- or zero-extended load data tagged with thread ID and destination register.

## Interface
- INDEX_W, 7, word-index width; matches the memory index ports (128 words, byte addresses 0x000–0x1FF)
- TID_W, 2, thread-ID width
- clk  in  1  clock; all registers update on the rising edge
- nReset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; handshake when req_valid & req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- req_tid  in  TID_W  issuing thread
- req_rd  in  5  load destination register
- ld_valid  out  1  one-cycle pulse, load result valid
- ld_data  out  32  extended load result
- ld_tid  out  TID_W  thread of the result
- ld_rd  out  5  destination of the result
- err_valid  out  1  one-cycle pulse, request rejected
- err_tid  out  TID_W  thread of the rejected request
- WriteCache  out  1  memory write enable
- ReadEnable  out  1  memory read enable
- CacheIndexWrite  out  INDEX_W  write word index
- CacheIndexRead  out  INDEX_W  read word index
- WriteDataCache  out  32  write data
- CacheData  in  32  memory read data, valid the cycle after ReadEnable

## Operation
- Word index = req_addr[8:2]; bits [31:9] are ignored, so addresses wrap modulo 512 bytes.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- An illegal or misaligned request is accepted but generates no memory access; it raises err_valid and err_tid.
- FSM states:
  - IDLE: req_ready=1.
    - Load → ReadEnable=1, CacheIndexRead=index; go to LD_WAIT.
    - SW → WriteCache=1, CacheIndexWrite=index, WriteDataCache=req_wdata; stay in IDLE.
    - SB/SH → ReadEnable=1 at index; latch lane, size, data and index; go to RMW.
    - Error → stay in IDLE.
  - LD_WAIT: req_ready=0. Select the lane from CacheData: byte at 8·addr[1:0], half at 16·addr[1]. Sign-extend (LB/LH) or zero-extend (LBU/LHU). Register into ld_data/ld_tid/ld_rd and set ld_valid. Go to IDLE.
  - RMW: req_ready=0. WriteCache=1 at the latched index. WriteDataCache = CacheData with only the target lane replaced. Go to IDLE.
- Memory control outputs are combinational from state and request. ld_* and err_* are registered.
- While nReset=0, WriteCache, ReadEnable and req_ready are forced to 0.

## Timing
- Reset values: state IDLE; ld_valid=0, ld_data=0, ld_tid=0, ld_rd=0, err_valid=0, err_tid=0.
- Load accepted in cycle T: ld_valid=1 in T+2; req_ready=1 again in T+2. Throughput is one load per 2 cycles.
- SW accepted in T: memory is written at the end of T; a new request may be accepted in T+1.
- SB/SH accepted in T: read issued in T; merged write in T+1; req_ready=1 in T+2.
- Error accepted in T: err_valid=1 in T+1; req_ready stays 1.
- ld_valid and err_valid are never high in the same cycle.
- Reset asserted mid-RMW: the write is abandoned and the memory word is unchanged. Reset asserted in LD_WAIT: no ld_valid is produced.
- req_valid while req_ready=0: ignored, with no side effects.

## Structure
- Shared package lsu_pkg:
  - enum state_t {IDLE, LD_WAIT, RMW}
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - function is_misaligned(funct3, addr[1:0])
- Sub-module lsu_lane_align: combinational load extraction/extension and store lane merge. Used twice, once for load and once for merge.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x010, then LW 0x010 → WriteCache pulse with index 4; ld_data=0xDEADBEEF in cycle T+2 with the correct tid/rd.
- Word 0x11223344 at 0x020; SB 0xAA to 0x022 → read then write at index 8; memory word becomes 0x11AA3344; req_ready is low for exactly 1 cycle.
- Word 0x80F07F01 at 0x030:
  - LB 0x033 → 0xFFFFFF80
  - LBU 0x033 → 0x00000080
  - LH 0x032 → 0xFFFF80F0
  - LHU 0x030 → 0x00007F01
- LW 0x012, SH 0x031, and funct3=011 → err_valid in T+1 with the correct err_tid; WriteCache and ReadEnable stay 0; the targeted memory words are unchanged.
- LW 0x204 with memory index 1 holding 0x5 → ld_data=0x5, confirming the wrap.
- SH issued, nReset pulsed low in the RMW cycle → no write; the word reads back unchanged; all outputs return to their reset values.
